inst_fetch_seq: RTL and testbench

//  Parametrised instruction fetch sequencer for NLP-16AF-class cores.
//  - Fetches variable-length instructions (1-3 words) over a req/ack memory port that tolerates wait states.
//  - Assembles the words and hands the complete instruction to the decoder over a valid/ready handshake.
//  - Supports branch redirect/flush and a memory-ack timeout with error reporting.

---
 rtl/inst_fetch_seq.sv | 164 ++++++++++++++++
 tb/tb_inst_fetch_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: fetches 1-3 word instructions over a req/ack
// memory port and presents them to the decoder over valid/ready.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   o_mem_req         memory read request
//   o_mem_addr        read address (current IP), registered
//   i_mem_ack         read done, i_mem_rdata valid this cycle
//   i_mem_rdata       read data
//   o_ir              assembled words, word k+1 at [k*DATA_W +: DATA_W]
//   o_ir_len          instruction length in words
//   o_ir_valid        instruction presented to the decoder
//   i_ir_ready        decoder accepts instruction
//   o_ir_ip           address of word 1 of the presented instruction
//   i_redirect        flush and restart fetch at i_redirect_ip
//   i_redirect_ip     new fetch address
//   o_err             one-cycle pulse on memory ack timeout
module inst_fetch_seq #(
  parameter int              DATA_W     = 16,
  parameter int              ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_IP = '0,
  parameter logic [3:0]      IMM_REG_ID = 4'hF,
  parameter int              TIMEOUT    = 15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic                o_mem_req,
  output logic [ADDR_W-1:0]   o_mem_addr,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic [3*DATA_W-1:0] o_ir,
  output logic [1:0]          o_ir_len,
  output logic                o_ir_valid,
  input  logic                i_ir_ready,
  output logic [ADDR_W-1:0]   o_ir_ip,
  input  logic                i_redirect,
  input  logic [ADDR_W-1:0]   i_redirect_ip,
  output logic                o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_FETCH,
    S_HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0]   ip_q;
  logic [ADDR_W-1:0]   ir_ip_q;
  logic [3*DATA_W-1:0] ir_q;
  logic [1:0]          cnt_q;
  logic [1:0]          len_q;
  logic [TW-1:0]       tcnt_q;
  logic                err_q;

  logic       take;
  logic       short_op;
  logic       has_imm;
  logic       done;
  logic       accept;
  logic       tmo;
  logic [3:0] w_hi;
  logic [3:0] w_lo;

  assign w_hi = i_mem_rdata[DATA_W-1 -: 4];
  assign w_lo = i_mem_rdata[DATA_W-5 -: 4];

  assign take     = (state_q == S_FETCH) && i_mem_ack;
  assign short_op = (w_hi == 4'b1100) || (w_hi == 4'b1101);
  assign has_imm  = (w_hi == IMM_REG_ID) || (w_lo == IMM_REG_ID);
  assign accept   = (state_q == S_HOLD) && i_ir_ready;
  assign tmo      = (state_q == S_FETCH) && !i_mem_ack
                 && (tcnt_q == TW'(TIMEOUT - 1));

  // Length is decided from word 1 (short opcodes) or word 2 (imm field).
  always_comb begin
    done = 1'b0;
    if (take) begin
      unique case (1'b1)
        cnt_q == 2'd0: done = short_op;
        cnt_q == 2'd1: done = !has_imm;
        default:       done = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_redirect) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: if (done)   state_d = S_HOLD;
        S_HOLD:  if (accept) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    o_mem_req  = (state_q == S_FETCH) && !i_rst;
    o_ir_valid = (state_q == S_HOLD) && !i_rst;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ip_q    <= RESET_IP;
      ir_ip_q <= RESET_IP;
      ir_q    <= '0;
      cnt_q   <= 2'd0;
      len_q   <= 2'd0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else if (i_redirect) begin
      // Any ack this cycle is dropped; an accept this cycle stands.
      ip_q   <= i_redirect_ip;
      ir_q   <= '0;
      cnt_q  <= 2'd0;
      len_q  <= 2'd0;
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= tmo;
      if (take) begin
        ip_q   <= ip_q + 1'b1;
        tcnt_q <= '0;
        unique case (cnt_q)
          2'd0:    ir_q[0*DATA_W +: DATA_W] <= i_mem_rdata;
          2'd1:    ir_q[1*DATA_W +: DATA_W] <= i_mem_rdata;
          default: ir_q[2*DATA_W +: DATA_W] <= i_mem_rdata;
        endcase
        if (cnt_q == 2'd0) ir_ip_q <= ip_q;
        if (done) begin
          cnt_q <= 2'd0;
          len_q <= cnt_q + 2'd1;
        end else begin
          cnt_q <= cnt_q + 2'd1;
        end
      end else if (state_q == S_FETCH) begin
        // Partial words are kept; the same address is re-requested.
        tcnt_q <= tmo ? '0 : tcnt_q + 1'b1;
      end
      if (accept) begin
        ir_q  <= '0;
        len_q <= 2'd0;
      end
    end
  end

  assign o_mem_addr = ip_q;
  assign o_ir       = ir_q;
  assign o_ir_len   = len_q;
  assign o_ir_ip    = ir_ip_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Directed bench for inst_fetch_seq with a scoreboard of expected
// instructions and a bench-driven memory responder.
module tb_inst_fetch_seq;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [47:0] ir;
  logic [1:0]  ir_len;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_ip;
  logic        redirect;
  logic [15:0] redirect_ip;
  logic        err;

  typedef struct {
    logic [47:0] ir;
    logic [1:0]  len;
    logic [15:0] ip;
  } exp_t;

  exp_t sb[$];
  logic [15:0] mem [0:65535];
  int n_chk;
  int n_fail;

  inst_fetch_seq dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata),
    .o_ir         (ir),
    .o_ir_len     (ir_len),
    .o_ir_valid   (ir_valid),
    .i_ir_ready   (ir_ready),
    .o_ir_ip      (ir_ip),
    .i_redirect   (redirect),
    .i_redirect_ip(redirect_ip),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!mem_req && k < 100) begin
      tick();
      k++;
    end
    if (!mem_req) chk("req_wait", 48'(mem_req), 48'd1);
  endtask

  task automatic serve(input int waits);
    wait_req();
    repeat (waits) tick();
    mem_ack   = 1'b1;
    mem_rdata = mem[mem_addr];
    tick();
    mem_ack   = 1'b0;
  endtask

  task automatic push(input logic [47:0] i, input logic [1:0] l,
                      input logic [15:0] a);
    exp_t e;
    e.ir  = i;
    e.len = l;
    e.ip  = a;
    sb.push_back(e);
  endtask

  task automatic accept(input int hold);
    exp_t e;
    int k;
    k = 0;
    while (!ir_valid && k < 100) begin
      tick();
      k++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 48'(sb.size()), 48'd1);
    end else begin
      e = sb.pop_front();
      chk("ir_valid", 48'(ir_valid), 48'd1);
      chk("ir", ir, e.ir);
      chk("ir_len", 48'(ir_len), 48'(e.len));
      chk("ir_ip", 48'(ir_ip), 48'(e.ip));
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", 48'(ir_valid), 48'd1);
        chk("hold_ir", ir, e.ir);
        chk("hold_req", 48'(mem_req), 48'd0);
      end
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("post_valid", 48'(ir_valid), 48'd0);
    chk("post_ir", ir, 48'd0);
    chk("post_req", 48'(mem_req), 48'd1);
  endtask

  initial begin
    logic err_seen;
    logic addr_moved;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'hC003;
    mem[16'h0001] = 16'h3000;
    mem[16'h0010] = 16'h0123;
    mem[16'h0011] = 16'h2F00;
    mem[16'h0012] = 16'hBEEF;
    mem[16'h0013] = 16'h1234;
    mem[16'h0014] = 16'h5555;
    mem[16'h0040] = 16'hD00A;
    mem[16'h0041] = 16'hC111;
    mem[16'hFFFF] = 16'h1234;

    rst         = 1'b1;
    mem_ack     = 1'b0;
    mem_rdata   = 16'h0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_ip = 16'h0;
    tick();
    tick();
    chk("rst_req", 48'(mem_req), 48'd0);
    chk("rst_addr", 48'(mem_addr), 48'd0);
    chk("rst_ir", ir, 48'd0);
    chk("rst_len", 48'(ir_len), 48'd0);
    chk("rst_valid", 48'(ir_valid), 48'd0);
    chk("rst_ip", 48'(ir_ip), 48'd0);
    chk("rst_err", 48'(err), 48'd0);
    rst = 1'b0;
    tick();

    // 1-word instruction, zero wait: valid one cycle after ack.
    chk("t1_req", 48'(mem_req), 48'd1);
    chk("t1_addr", 48'(mem_addr), 48'd0);
    push(48'h0000_0000_C003, 2'd1, 16'h0000);
    mem_ack   = 1'b1;
    mem_rdata = mem[mem_addr];
    tick();
    mem_ack   = 1'b0;
    chk("t1_lat", 48'(ir_valid), 48'd1);
    accept(0);
    chk("t1_next", 48'(mem_addr), 48'd1);

    redirect    = 1'b1;
    redirect_ip = 16'h0010;
    tick();
    redirect    = 1'b0;
    chk("rd10_addr", 48'(mem_addr), 48'h10);
    chk("rd10_req", 48'(mem_req), 48'd1);

    // 3-word instruction via second register field, 2 wait states.
    push(48'hBEEF_2F00_0123, 2'd3, 16'h0010);
    serve(2);
    serve(2);
    serve(2);
    accept(5);
    chk("t2_next", 48'(mem_addr), 48'h13);

    // Redirect in the same cycle as the ack of word 2.
    serve(0);
    chk("t4_w2addr", 48'(mem_addr), 48'h14);
    mem_ack     = 1'b1;
    mem_rdata   = mem[mem_addr];
    redirect    = 1'b1;
    redirect_ip = 16'h0040;
    tick();
    mem_ack  = 1'b0;
    redirect = 1'b0;
    chk("t4_addr", 48'(mem_addr), 48'h40);
    chk("t4_req", 48'(mem_req), 48'd1);
    chk("t4_valid", 48'(ir_valid), 48'd0);
    chk("t4_ir", ir, 48'd0);
    push(48'h0000_0000_D00A, 2'd1, 16'h0040);
    serve(0);
    accept(0);

    // Ack timeout: pulse after 15 stalled cycles, same address kept.
    err_seen   = 1'b0;
    addr_moved = 1'b0;
    for (int c = 0; c < 15; c++) begin
      err_seen   = err_seen | err;
      addr_moved = addr_moved | (mem_addr != 16'h0041) | !mem_req;
      tick();
    end
    chk("t5_early_err", 48'(err_seen), 48'd0);
    chk("t5_addr_held", 48'(addr_moved), 48'd0);
    chk("t5_err", 48'(err), 48'd1);
    chk("t5_addr", 48'(mem_addr), 48'h41);
    push(48'h0000_0000_C111, 2'd1, 16'h0041);
    mem_ack   = 1'b1;
    mem_rdata = mem[mem_addr];
    tick();
    mem_ack   = 1'b0;
    chk("t5_err_end", 48'(err), 48'd0);
    accept(0);

    // 2-word instruction straddling the address wrap.
    redirect    = 1'b1;
    redirect_ip = 16'hFFFF;
    tick();
    redirect    = 1'b0;
    chk("t6_addr", 48'(mem_addr), 48'hFFFF);
    push(48'h0000_C003_1234, 2'd2, 16'hFFFF);
    serve(1);
    chk("t6_wrap", 48'(mem_addr), 48'h0000);
    serve(0);
    accept(0);
    chk("t6_next", 48'(mem_addr), 48'h0001);

    // Reset mid-fetch drops the partial instruction.
    serve(0);
    rst = 1'b1;
    tick();
    chk("t6_rst_req", 48'(mem_req), 48'd0);
    chk("t6_rst_addr", 48'(mem_addr), 48'd0);
    rst = 1'b0;
    tick();
    chk("t6_rq", 48'(mem_req), 48'd1);
    chk("t6_ra", 48'(mem_addr), 48'd0);
    push(48'h0000_0000_C003, 2'd1, 16'h0000);
    serve(0);
    accept(0);
    chk("sb_drained", 48'(sb.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
